// File: rtl/cla_seq_adder.sv
// Multi-cycle WORDS*16-bit add/subtract sequencer around one shared 16-bit carry-lookahead adder.
// Optional `zero` result flag is built only when CLA_SEQ_ZERO_FLAG_EN is defined.

module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] S,
    output logic        cout,
    output logic        p_1_16,
    output logic        g_1_16
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    // Four 4-bit lookahead groups; group carries come from the group generate/propagate terms.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                c[i] = gc[i/4];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
        S      = p ^ c;
        p_1_16 = &gp;
        g_1_16 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
        cout   = gc[4];
    end
endmodule

module cla_seq_adder #(
    parameter int WORDS = 4,
    parameter int width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [WORDS*width-1:0] a,
    input  logic [WORDS*width-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*width-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
`ifdef CLA_SEQ_ZERO_FLAG_EN
    output logic                   zero,
`endif
    output logic [1:0]             state_o
);
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          carry_q;
    logic [WORDS-1:0][width-1:0]   a_q;
    logic [WORDS-1:0][width-1:0]   b_q;
    logic [WORDS-1:0][width-1:0]   sum_q;
    logic                          cout_q;
    logic                          ovf_q;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic                          zero_q;
`endif

    logic [width-1:0] cla_a;
    logic [width-1:0] cla_b;
    logic [width-1:0] cla_s;
    logic             cla_cout;
    logic             cla_p_unused;
    logic             cla_g_unused;
    logic             last_chunk;

    assign cla_a      = a_q[idx_q];
    assign cla_b      = b_q[idx_q];
    assign last_chunk = (idx_q == IDX_W'(WORDS - 1));

    CLA_16bit u_cla (
        .a      (cla_a),
        .b      (cla_b),
        .cin    (carry_q),
        .S      (cla_s),
        .cout   (cla_cout),
        .p_1_16 (cla_p_unused),
        .g_1_16 (cla_g_unused)
    );

    // Handshake: a request transfers on an edge where in_valid && in_ready, a result transfers
    // on an edge where out_valid && out_ready; both ready/valid are decoded from state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        idx_q   <= '0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                        zero_q  <= 1'b1;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= cla_s;
                    carry_q      <= cla_cout;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                    zero_q       <= zero_q & (cla_s == '0);
`endif
                    if (last_chunk) begin
                        // Overflow uses the possibly inverted B, so one rule covers add and subtract.
                        cout_q  <= cla_cout;
                        ovf_q   <= (cla_a[width-1] == cla_b[width-1]) && (cla_s[width-1] != cla_a[width-1]);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif
endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder (WORDS=4): directed and random operations against a full-width
// arithmetic reference model; also covers the zero flag when CLA_SEQ_ZERO_FLAG_EN is defined.

module tb_cla_seq_adder;
    localparam int WORDS = 4;
    localparam int W     = WORDS * 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   state_o;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];
    int           acc_cyc[$];

    always #5 clk = ~clk;

    cla_seq_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
`ifdef CLA_SEQ_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .state_o   (state_o)
    );

    // Reference result packed as {ovf, cout, sum}, from plain wide signed/unsigned arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        logic signed [W:0] res;
        logic [W:0]        u;
        logic              c;
        if (sub) begin
            res = $signed({x[W-1], x}) - $signed({y[W-1], y});
            c   = (x >= y);
        end else begin
            res = $signed({x[W-1], x}) + $signed({y[W-1], y});
            u   = {1'b0, x} + {1'b0, y};
            c   = u[W];
        end
        return {res[W] ^ res[W-1], c, res[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, "_sum"}, sum, e[W-1:0]);
        check({tag, "_cout"}, cout, e[W]);
        check({tag, "_ovf"}, ovf, e[W+1]);
`ifdef CLA_SEQ_ZERO_FLAG_EN
        check({tag, "_zero"}, zero, (e[W-1:0] == '0));
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input int hold);
        logic [W+1:0] e;
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_idle"}, in_ready, 1);
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = rand_w(); b = rand_w(); op_sub = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, WORDS);
        e = model(x, y, sub);
        check_result(tag, e);
        check({tag, "_busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rand_w(); b = rand_w();
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_busy"}, in_ready, 0);
            check_result({tag, "_hold"}, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, out_valid, 0);
        check({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W-1:0] bx [4];
        logic [W-1:0] by [4];
        logic         bs [4];
        int k;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
`ifdef CLA_SEQ_ZERO_FLAG_EN
        check("rst_zero", zero, 0);
`endif
        rst = 1'b0;
        tick();

        run_op("add_chunk_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0);
        run_op("add_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
        run_op("sub_borrow", 64'h0, 64'h1, 1'b1, 0);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 0);
        run_op("backpressure", 64'h1234_5678_0000_0000, 64'h0000_0000_9ABC_DEF0, 1'b0, 5);

        // Abort an operation after two chunks have been written.
        a = rand_w(); b = rand_w(); op_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        run_op("after_abort", 64'h5, 64'h3, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            run_op("random", rand_w(), rand_w(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Back-to-back with out_ready tied high.
        for (int i = 0; i < 4; i++) begin
            bx[i] = rand_w(); by[i] = rand_w(); bs[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        k = 0;
        cyc = 0;
        while ((k < 4 || exp_q.size() > 0) && cyc < 80) begin
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_result("b2b", e);
                end else begin
                    check("b2b_unexpected_result", out_valid, 0);
                end
            end
            if (in_ready && k < 4) begin
                a = bx[k]; b = by[k]; op_sub = bs[k]; in_valid = 1'b1;
                exp_q.push_back(model(bx[k], by[k], bs[k]));
                acc_cyc.push_back(cyc);
                k++;
            end else begin
                in_valid = (k < 4);
                a = rand_w(); b = rand_w(); op_sub = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_all_accepted", k, 4);
        check("b2b_all_returned", exp_q.size(), 0);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], WORDS + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
